biriscv_csr_hpm: RTL and testbench
==================================

Name: biriscv_csr_hpm

Overview:
- Machine-mode counter CSR block: mcycle, minstret and NUM_COUNTERS programmable mhpmcounters with mhpmevent selectors and mcountinhibit.
- Sits beside the CSR unit. The CSR unit's issue-stage read address feeds it; read data returns at E1 alongside the CSR regfile data. Writeback-stage CSR writes update it.
- Generalises the fixed counters to parametrised count, width and event set, with dual-issue retire counting and per-counter overflow flags.

Parameters:
- NUM_COUNTERS, 4, implemented mhpmcounter3..(3+NUM_COUNTERS-1); legal range 0..29.
- COUNTER_W, 64, implemented counter bits; legal range 33..64; unimplemented upper bits read 0.
- EVENT_W, 8, number of event inputs; legal range 1..255.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- csr_ren_i  in  1  read strobe (issue stage)
- csr_raddr_i  in  12  read CSR address
- csr_rdata_o  out  32  registered read data (E1)
- csr_hit_o  out  1  registered: address is a counter CSR owned by this block
- csr_wen_i  in  1  write strobe (writeback)
- csr_waddr_i  in  12  write CSR address
- csr_wdata_i  in  32  write data
- retire_count_i  in  2  instructions retired this cycle, 0..2; value 3 is treated as 2
- event_i  in  EVENT_W  per-cycle event pulses
- ovf_o  out  NUM_COUNTERS  sticky overflow flag per mhpmcounter

Behaviour:
- Reset (rst_ni low, async): all counters, mhpmevent and mcountinhibit = 0; csr_rdata_o = 0; csr_hit_o = 0; ovf_o = 0.
- Address map:
  - mcycle B00/B80; minstret B02/B82.
  - mhpmcounterN B00+N / B80+N, N = 3..31.
  - mhpmeventN 320+N, N = 3..31; mcountinhibit 320.
  - User read-only aliases C00..C1F / C80..C9F map to the same counters. Writes to the aliases are ignored here; fault detection is the CSR unit's job.
  - B80-range and C80-range addresses return bits [COUNTER_W-1:32], zero-extended.
- Unimplemented N in 3..31 (N >= 3+NUM_COUNTERS): reads 0 with hit = 1; writes ignored.
- Read:
  - If csr_ren_i is high in cycle T, csr_rdata_o and csr_hit_o are valid in T+1 and hold until the next csr_ren_i.
  - When csr_ren_i is low, outputs are forced to 0 the next cycle.
  - A read returns the value before any write or increment in the same cycle.
  - Non-counter addresses give hit = 0 and data = 0.
- mcountinhibit:
  - Bit 0 = CY, bit 2 = IR, bit N = HPM N.
  - Bit 1 and bits for unimplemented N are hardwired 0.
- Increment rules, per cycle, when the counter is not inhibited:
  - mcycle += 1.
  - minstret += retire_count_i, so 0, 1 or 2.
  - mhpmcounterN += 1 when its selected event is high.
- mhpmevent:
  - 8-bit register; reads zero-extended to 32.
  - Value v in 1..EVENT_W selects event_i[v-1].
  - v = 0 or v > EVENT_W counts nothing.
- Arithmetic: counters wrap modulo 2^COUNTER_W; the carry from low to high half is internal, no intermediate states.
- Overflow: ovf_o[N-3] sets in the cycle mhpmcounterN wraps all-ones to 0. It clears on any write to either half of that counter. If a wrap and a clearing write occur in the same cycle, the write wins and the flag stays 0.
- Write collision: a write to a counter half replaces that half. The increment for that counter is dropped in that cycle, including any carry into the other half. The other half holds.
- Writes to mcountinhibit and mhpmevent take effect from the next cycle; counting in the write cycle uses the old value.

Test Plan:
- Reset mid-count: mcycle = 0x1234 → assert rst_ni low for 1 cycle → all counters, ovf_o and csr_rdata_o read 0; counting resumes the cycle after release.
- Dual retire: retire_count_i = 2 for 5 cycles, then 1 for 3 cycles → read B02 returns 13. With mcountinhibit = 0x4, minstret holds.
- Low-to-high carry: write B00 = 0xFFFF_FFFE, B80 = 0 → two cycles later B00 reads 0x0000_0000 and B80 reads 0x0000_0001.
- HPM event and overflow: COUNTER_W = 40, mhpmevent3 = 2, mhpmcounter3 = 0xFF_FFFF_FFFF → event_i[1] pulse → counter = 0 and ovf_o[0] = 1. Write B03 = 5 → ovf_o[0] = 0.
- Write collision: mcycle = 100; write B00 = 7 in cycle T → reads 7 in T+1 and 8 in T+2.
- Address edges: with NUM_COUNTERS = 4, read B1F gives hit = 1, data = 0. Read C00 equals mcycle. Read 300 gives hit = 0. mhpmevent3 = 0x1FF reads 0xFF.

Source files
------------

// File: rtl/biriscv_csr_hpm.sv
// Machine-mode counter CSRs: mcycle, minstret, mhpmcounter3.. with event
// selectors, mcountinhibit and sticky per-counter overflow flags.
module biriscv_csr_hpm #(
    parameter int NUM_COUNTERS = 4,
    parameter int COUNTER_W    = 64,
    parameter int EVENT_W      = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    csr_ren_i,
    input  logic [11:0]             csr_raddr_i,
    output logic [31:0]             csr_rdata_o,
    output logic                    csr_hit_o,
    input  logic                    csr_wen_i,
    input  logic [11:0]             csr_waddr_i,
    input  logic [31:0]             csr_wdata_i,
    input  logic [1:0]              retire_count_i,
    input  logic [EVENT_W-1:0]      event_i,
    output logic [NUM_COUNTERS-1:0] ovf_o
);

    // Keep arrays non-empty even when no programmable counters are built.
    localparam int NC = (NUM_COUNTERS > 0) ? NUM_COUNTERS : 1;
    localparam int HW = COUNTER_W - 32;

    typedef logic [COUNTER_W-1:0] cnt_t;

    cnt_t        r_mcycle;
    cnt_t        r_minstret;
    cnt_t        r_hpm   [NC];
    logic [7:0]  r_event [NC];
    logic [31:0] r_inhibit;
    logic [NC-1:0] r_ovf;
    logic [31:0] r_rdata;
    logic        r_hit;

    logic [4:0]  w_widx;
    logic        w_wlo;
    logic        w_whi;
    logic        w_wev;
    logic [1:0]  w_ret;
    logic [31:0] w_inh_mask;
    cnt_t        w_mcycle_nxt;
    cnt_t        w_minstret_nxt;
    cnt_t        w_hpm_nxt [NC];
    logic [NC-1:0] w_hpm_wlo;
    logic [NC-1:0] w_hpm_whi;
    logic [NC-1:0] w_hpm_inc;
    logic [NC-1:0] w_ovf_nxt;
    logic [6:0]  w_rgrp;
    logic [4:0]  w_ridx;
    logic        w_rd_is_cnt;
    logic        w_rd_is_hi;
    cnt_t        w_rd_cnt;
    logic [31:0] w_rd_data;
    logic        w_rd_hit;

    // Write group decode: B00-B1F low halves, B80-B9F high halves, 320-33F events.
    assign w_widx = csr_waddr_i[4:0];
    assign w_wlo  = csr_wen_i && (csr_waddr_i[11:5] == 7'h58);
    assign w_whi  = csr_wen_i && (csr_waddr_i[11:5] == 7'h5C);
    assign w_wev  = csr_wen_i && (csr_waddr_i[11:5] == 7'h19);

    // A write to one half replaces it and drops this cycle's increment
    // entirely, so no carry leaks into the other half.
    function automatic cnt_t f_step(input cnt_t cnt, input logic [1:0] inc,
                                    input logic wlo, input logic whi,
                                    input logic [31:0] wd);
        cnt_t res;
        if (wlo)
            res = {cnt[COUNTER_W-1:32], wd};
        else if (whi)
            res = {wd[HW-1:0], cnt[31:0]};
        else
            res = cnt + cnt_t'(inc);
        return res;
    endfunction

    // Selector v counts event_i[v-1]; 0 and out-of-range values count nothing.
    function automatic logic f_evt_sel(input logic [7:0] v, input logic [EVENT_W-1:0] ev);
        logic sel;
        sel = 1'b0;
        for (int e = 0; e < EVENT_W; e++)
            if (v == 8'(e + 1))
                sel = sel | ev[e];
        return sel;
    endfunction

    // Next-state for every counter and overflow flag.
    always_comb begin
        w_inh_mask = 32'h0000_0005;
        for (int i = 0; i < NUM_COUNTERS; i++)
            w_inh_mask[3+i] = 1'b1;
        w_ret = (retire_count_i == 2'd3) ? 2'd2 : retire_count_i;
        w_mcycle_nxt = f_step(r_mcycle, {1'b0, !r_inhibit[0]},
                              w_wlo && (w_widx == 5'd0), w_whi && (w_widx == 5'd0), csr_wdata_i);
        w_minstret_nxt = f_step(r_minstret, r_inhibit[2] ? 2'd0 : w_ret,
                                w_wlo && (w_widx == 5'd2), w_whi && (w_widx == 5'd2), csr_wdata_i);
        w_hpm_wlo = '0;
        w_hpm_whi = '0;
        w_hpm_inc = '0;
        w_ovf_nxt = r_ovf;
        for (int i = 0; i < NC; i++) begin
            w_hpm_wlo[i] = w_wlo && (w_widx == 5'(3 + i));
            w_hpm_whi[i] = w_whi && (w_widx == 5'(3 + i));
            w_hpm_inc[i] = !r_inhibit[3+i] && f_evt_sel(r_event[i], event_i);
            w_hpm_nxt[i] = f_step(r_hpm[i], {1'b0, w_hpm_inc[i]},
                                  w_hpm_wlo[i], w_hpm_whi[i], csr_wdata_i);
            if (w_hpm_wlo[i] || w_hpm_whi[i])
                w_ovf_nxt[i] = 1'b0;
            else if (w_hpm_inc[i] && (&r_hpm[i]))
                w_ovf_nxt[i] = 1'b1;
        end
    end

    // Counter, selector and inhibit state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mcycle   <= '0;
            r_minstret <= '0;
            r_inhibit  <= '0;
            r_ovf      <= '0;
            for (int i = 0; i < NC; i++) begin
                r_hpm[i]   <= '0;
                r_event[i] <= '0;
            end
        end else begin
            r_mcycle   <= w_mcycle_nxt;
            r_minstret <= w_minstret_nxt;
            r_ovf      <= w_ovf_nxt;
            if (w_wev && (w_widx == 5'd0))
                r_inhibit <= csr_wdata_i & w_inh_mask;
            for (int i = 0; i < NC; i++) begin
                r_hpm[i] <= w_hpm_nxt[i];
                if (w_wev && (w_widx == 5'(3 + i)) && (i < NUM_COUNTERS))
                    r_event[i] <= csr_wdata_i[7:0];
            end
        end
    end

    // Read decode against pre-update state; N=1 (time) is not owned here.
    always_comb begin
        w_rgrp      = csr_raddr_i[11:5];
        w_ridx      = csr_raddr_i[4:0];
        w_rd_is_cnt = (w_rgrp == 7'h58) || (w_rgrp == 7'h5C) ||
                      (w_rgrp == 7'h60) || (w_rgrp == 7'h64);
        w_rd_is_hi  = (w_rgrp == 7'h5C) || (w_rgrp == 7'h64);
        w_rd_cnt    = '0;
        w_rd_data   = '0;
        w_rd_hit    = 1'b0;
        if (w_ridx == 5'd0)
            w_rd_cnt = r_mcycle;
        else if (w_ridx == 5'd2)
            w_rd_cnt = r_minstret;
        for (int i = 0; i < NUM_COUNTERS; i++)
            if (w_ridx == 5'(3 + i))
                w_rd_cnt = r_hpm[i];
        if (w_rd_is_cnt) begin
            w_rd_hit  = (w_ridx != 5'd1);
            w_rd_data = w_rd_is_hi ? 32'(w_rd_cnt[COUNTER_W-1:32]) : w_rd_cnt[31:0];
        end else if (w_rgrp == 7'h19) begin
            if (w_ridx == 5'd0) begin
                w_rd_hit  = 1'b1;
                w_rd_data = r_inhibit;
            end else if (w_ridx >= 5'd3) begin
                w_rd_hit = 1'b1;
                for (int i = 0; i < NUM_COUNTERS; i++)
                    if (w_ridx == 5'(3 + i))
                        w_rd_data = {24'd0, r_event[i]};
            end
        end
    end

    // Registered read port; idle cycles return zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rdata <= '0;
            r_hit   <= 1'b0;
        end else if (csr_ren_i) begin
            r_rdata <= w_rd_data;
            r_hit   <= w_rd_hit;
        end else begin
            r_rdata <= '0;
            r_hit   <= 1'b0;
        end
    end

    assign csr_rdata_o = r_rdata;
    assign csr_hit_o   = r_hit;
    assign ovf_o       = r_ovf[NUM_COUNTERS-1:0];

endmodule

// File: tb/tb_biriscv_csr_hpm.sv
// Directed bench for biriscv_csr_hpm with 4 counters, 40-bit width, 8 events.
module tb_biriscv_csr_hpm;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        csr_ren_i = 1'b0;
    logic [11:0] csr_raddr_i = '0;
    logic [31:0] csr_rdata_o;
    logic        csr_hit_o;
    logic        csr_wen_i = 1'b0;
    logic [11:0] csr_waddr_i = '0;
    logic [31:0] csr_wdata_i = '0;
    logic [1:0]  retire_count_i = '0;
    logic [7:0]  event_i = '0;
    logic [3:0]  ovf_o;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] d;
    logic        h;

    biriscv_csr_hpm #(.NUM_COUNTERS(4), .COUNTER_W(40), .EVENT_W(8)) u_dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .csr_ren_i      (csr_ren_i),
        .csr_raddr_i    (csr_raddr_i),
        .csr_rdata_o    (csr_rdata_o),
        .csr_hit_o      (csr_hit_o),
        .csr_wen_i      (csr_wen_i),
        .csr_waddr_i    (csr_waddr_i),
        .csr_wdata_i    (csr_wdata_i),
        .retire_count_i (retire_count_i),
        .event_i        (event_i),
        .ovf_o          (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns the value captured at the following posedge.
    task automatic rd(input logic [11:0] a, output logic [31:0] rdat, output logic rhit);
        csr_ren_i   = 1'b1;
        csr_raddr_i = a;
        @(negedge clk_i);
        rdat      = csr_rdata_o;
        rhit      = csr_hit_o;
        csr_ren_i = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] v);
        csr_wen_i   = 1'b1;
        csr_waddr_i = a;
        csr_wdata_i = v;
        @(negedge clk_i);
        csr_wen_i = 1'b0;
    endtask

    task automatic pulse(input logic [7:0] ev);
        event_i = ev;
        @(negedge clk_i);
        event_i = '0;
    endtask

    initial begin
        @(negedge clk_i);
        chk("rst_rdata", csr_rdata_o, 32'h0);
        chk("rst_hit", {31'd0, csr_hit_o}, 32'h0);
        chk("rst_ovf", {28'd0, ovf_o}, 32'h0);
        rst_ni = 1'b1;

        // write collision on mcycle
        wr(12'hB00, 32'h1234);
        rd(12'hB00, d, h);
        chk("mcycle_wr", d, 32'h1234);
        chk("mcycle_hit", {31'd0, h}, 32'h1);
        wr(12'hB00, 32'd7);
        rd(12'hB00, d, h);
        chk("coll_t1", d, 32'd7);
        rd(12'hB00, d, h);
        chk("coll_t2", d, 32'd8);

        // asynchronous reset mid-count
        rst_ni = 1'b0;
        #1;
        chk("async_rdata", csr_rdata_o, 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        rd(12'hB00, d, h);
        chk("post_rst_mcycle0", d, 32'h0);
        rd(12'hB00, d, h);
        chk("post_rst_mcycle1", d, 32'h1);
        rd(12'hB02, d, h);
        chk("post_rst_minstret", d, 32'h0);
        chk("post_rst_ovf", {28'd0, ovf_o}, 32'h0);

        // dual retire
        retire_count_i = 2'd2;
        repeat (5) @(negedge clk_i);
        retire_count_i = 2'd1;
        repeat (3) @(negedge clk_i);
        retire_count_i = 2'd0;
        rd(12'hB02, d, h);
        chk("minstret_13", d, 32'd13);
        retire_count_i = 2'd3;
        repeat (2) @(negedge clk_i);
        retire_count_i = 2'd0;
        rd(12'hB02, d, h);
        chk("retire3_as2", d, 32'd17);
        wr(12'h320, 32'h4);
        rd(12'h320, d, h);
        chk("inhibit_rd", d, 32'h4);
        retire_count_i = 2'd2;
        repeat (3) @(negedge clk_i);
        retire_count_i = 2'd0;
        rd(12'hB02, d, h);
        chk("minstret_inhib", d, 32'd17);

        // low-to-high carry
        wr(12'h320, 32'h0);
        wr(12'hB80, 32'h0);
        wr(12'hB00, 32'hFFFF_FFFE);
        repeat (2) @(negedge clk_i);
        rd(12'hB00, d, h);
        chk("carry_lo", d, 32'h0);
        rd(12'hB80, d, h);
        chk("carry_hi", d, 32'h1);

        wr(12'h320, 32'hFFFF_FFFF);
        rd(12'h320, d, h);
        chk("inhibit_mask", d, 32'h0000_007D);

        // hpm event and overflow
        wr(12'h323, 32'd2);
        wr(12'hB83, 32'hFF);
        wr(12'hB03, 32'hFFFF_FFFF);
        wr(12'h320, 32'h5);
        pulse(8'h02);
        chk("ovf_set", {28'd0, ovf_o}, 32'h1);
        rd(12'hB03, d, h);
        chk("hpm_wrap_lo", d, 32'h0);
        rd(12'hB83, d, h);
        chk("hpm_wrap_hi", d, 32'h0);
        wr(12'hB03, 32'd5);
        chk("ovf_clr", {28'd0, ovf_o}, 32'h0);
        rd(12'hB03, d, h);
        chk("hpm_wr5", d, 32'd5);
        pulse(8'hFD);
        rd(12'hB03, d, h);
        chk("hpm_other_evt", d, 32'd5);

        // wrap and clearing write in the same cycle
        wr(12'hB83, 32'hFF);
        wr(12'hB03, 32'hFFFF_FFFF);
        event_i     = 8'h02;
        csr_wen_i   = 1'b1;
        csr_waddr_i = 12'hB03;
        csr_wdata_i = 32'd9;
        @(negedge clk_i);
        event_i   = '0;
        csr_wen_i = 1'b0;
        chk("ovf_write_wins", {28'd0, ovf_o}, 32'h0);
        rd(12'hB03, d, h);
        chk("coll_hpm_lo", d, 32'd9);
        rd(12'hB83, d, h);
        chk("coll_hpm_hi", d, 32'hFF);

        // selector range edges
        wr(12'h323, 32'd9);
        pulse(8'hFF);
        rd(12'hB03, d, h);
        chk("sel_over_range", d, 32'd9);
        wr(12'h323, 32'd8);
        pulse(8'h80);
        rd(12'hB03, d, h);
        chk("sel_top", d, 32'd10);
        rd(12'hC03, d, h);
        chk("alias_c03", d, 32'd10);
        rd(12'hC83, d, h);
        chk("alias_c83", d, 32'hFF);

        // aliases and address edges
        wr(12'hB00, 32'h0000_ABCD);
        rd(12'hC00, d, h);
        chk("alias_c00", d, 32'h0000_ABCD);
        wr(12'hB80, 32'hFFFF_FF5A);
        rd(12'hC80, d, h);
        chk("alias_c80_w40", d, 32'h5A);
        wr(12'hC00, 32'h0);
        rd(12'hB00, d, h);
        chk("alias_wr_ignored", d, 32'h0000_ABCD);
        @(negedge clk_i);
        chk("idle_rdata", csr_rdata_o, 32'h0);
        chk("idle_hit", {31'd0, csr_hit_o}, 32'h0);
        rd(12'hB1F, d, h);
        chk("b1f_hit", {31'd0, h}, 32'h1);
        chk("b1f_data", d, 32'h0);
        wr(12'hB07, 32'h55);
        rd(12'hB07, d, h);
        chk("b07_unimpl", d, 32'h0);
        rd(12'h300, d, h);
        chk("300_hit", {31'd0, h}, 32'h0);
        chk("300_data", d, 32'h0);
        rd(12'h321, d, h);
        chk("321_hit", {31'd0, h}, 32'h0);
        wr(12'h323, 32'h1FF);
        rd(12'h323, d, h);
        chk("evt_8bit", d, 32'hFF);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
